// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store ports, the arbiter and the single-port RAM.
// The master side is the CPU plus RAM; the slave side is the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              m0_req;
    logic [AW-1:0]     m0_addr;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DW-1:0]     m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [AW-1:0]     m1_addr;
    logic [DW-1:0]     m1_wdata;
    logic [DW/8-1:0]   m1_wstrb;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DW-1:0]     m1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic [DW-1:0]     mem_rdata;

    modport master (
        output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port (m0) and the load/store port (m1).
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [2:0] LAT  = 3'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t          state_q, state_d;
    logic [2:0]      lat_cnt_q, lat_cnt_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            owner_q, owner_d;

    logic            rd_done, arb_ok, pick_m0, gnt0, gnt1, is_write;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   wdata_sel;
    logic [DW/8-1:0] wstrb_sel;

    // Arbitration is open in IDLE and on the last cycle of an outstanding read.
    always_comb begin
        rd_done   = (state_q == WAIT) && (lat_cnt_q == LAT);
        arb_ok    = rstn && ((state_q == IDLE) || rd_done);
        pick_m0   = bus.m0_req && (!bus.m1_req || (starve_cnt_q == SMAX));
        gnt0      = arb_ok && pick_m0;
        gnt1      = arb_ok && bus.m1_req && !pick_m0;
        is_write  = gnt1 && bus.m1_we;
        addr_sel  = gnt0 ? bus.m0_addr : bus.m1_addr;
        wdata_sel = is_write ? bus.m1_wdata : '0;
        wstrb_sel = is_write ? bus.m1_wstrb : '0;
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.mem_en    = gnt0 || gnt1;
    assign bus.mem_we    = is_write;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.mem_wstrb = wstrb_sel;
    assign bus.m0_rvalid = rd_done && !owner_q;
    assign bus.m1_rvalid = rd_done && owner_q;
    assign bus.m0_rdata  = (rd_done && !owner_q) ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = (rd_done && owner_q) ? bus.mem_rdata : '0;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        if ((gnt0 || gnt1) && !is_write) begin
            state_d   = WAIT;
            lat_cnt_d = 3'd1;
            owner_d   = gnt1;
        end else if (rd_done || (state_q == IDLE)) begin
            state_d   = IDLE;
            lat_cnt_d = '0;
        end else begin
            lat_cnt_d = lat_cnt_q + 3'd1;
        end
        // Only data wins taken while a fetch is waiting count as starvation.
        if (gnt0) begin
            starve_cnt_d = '0;
        end else if (gnt1 && bus.m0_req && (starve_cnt_q != SMAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            owner_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) checked cycle by cycle
// against a timestamp-based reference model of the arbitration and read-return rules.
module tb_mem_port_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SMAX  = 4;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) ifa ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) ifb ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_A), .STARVE_MAX(SMAX)) dut_a (
        .clk(clk), .rstn(rstn), .bus(ifa.slave));
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_B), .STARVE_MAX(SMAX)) dut_b (
        .clk(clk), .rstn(rstn), .bus(ifb.slave));

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
    endfunction

    // RAM models: a delay line of {read valid, address}, data returned LAT cycles after mem_en.
    logic [AW:0] sha [8] = '{default: '0};
    logic [AW:0] shb [8] = '{default: '0};
    always @(posedge clk) begin
        sha[0] <= {ifa.mem_en & ~ifa.mem_we, ifa.mem_addr};
        shb[0] <= {ifb.mem_en & ~ifb.mem_we, ifb.mem_addr};
        for (int i = 1; i < 8; i++) begin
            sha[i] <= sha[i-1];
            shb[i] <= shb[i-1];
        end
    end
    assign ifa.mem_rdata = sha[LAT_A-1][AW] ? memf(sha[LAT_A-1][AW-1:0]) : '0;
    assign ifb.mem_rdata = shb[LAT_B-1][AW] ? memf(shb[LAT_B-1][AW-1:0]) : '0;

    int tests = 0;
    int fails = 0;
    int k = 0;
    int cyc = 0;
    int lat_of [2] = '{LAT_A, LAT_B};

    // Reference model: at most one outstanding read, described by its owner, address and due cycle.
    int          starve [2];
    bit          pv     [2];
    bit          pport  [2];
    logic [31:0] paddr  [2];
    int          pdue   [2];

    // Requester state for the instance currently under test (the other one sees idle inputs).
    logic        q0, q1, we1;
    logic [31:0] a0, a1, wd1;
    logic [3:0]  ws1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut=%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic apply();
        ifa.m0_req   = (k == 0) ? q0  : 1'b0;  ifb.m0_req   = (k == 1) ? q0  : 1'b0;
        ifa.m0_addr  = (k == 0) ? a0  : '0;    ifb.m0_addr  = (k == 1) ? a0  : '0;
        ifa.m1_req   = (k == 0) ? q1  : 1'b0;  ifb.m1_req   = (k == 1) ? q1  : 1'b0;
        ifa.m1_we    = (k == 0) ? we1 : 1'b0;  ifb.m1_we    = (k == 1) ? we1 : 1'b0;
        ifa.m1_addr  = (k == 0) ? a1  : '0;    ifb.m1_addr  = (k == 1) ? a1  : '0;
        ifa.m1_wdata = (k == 0) ? wd1 : '0;    ifb.m1_wdata = (k == 1) ? wd1 : '0;
        ifa.m1_wstrb = (k == 0) ? ws1 : '0;    ifb.m1_wstrb = (k == 1) ? ws1 : '0;
    endtask

    task automatic check_cycle(output bit e0, output bit e1, output logic o0, output logic o1,
                               output logic rv0);
        logic        og0, og1, oen, owe, orv0, orv1;
        logic [31:0] oaddr, owd, ord0, ord1;
        logic [3:0]  ows;
        bit          done, free, ewe;
        if (k == 0) begin
            og0 = ifa.m0_gnt; og1 = ifa.m1_gnt; oen = ifa.mem_en; owe = ifa.mem_we;
            oaddr = ifa.mem_addr; owd = ifa.mem_wdata; ows = ifa.mem_wstrb;
            orv0 = ifa.m0_rvalid; orv1 = ifa.m1_rvalid; ord0 = ifa.m0_rdata; ord1 = ifa.m1_rdata;
        end else begin
            og0 = ifb.m0_gnt; og1 = ifb.m1_gnt; oen = ifb.mem_en; owe = ifb.mem_we;
            oaddr = ifb.mem_addr; owd = ifb.mem_wdata; ows = ifb.mem_wstrb;
            orv0 = ifb.m0_rvalid; orv1 = ifb.m1_rvalid; ord0 = ifb.m0_rdata; ord1 = ifb.m1_rdata;
        end
        if (!rstn) begin
            for (int j = 0; j < 2; j++) begin
                pv[j] = 1'b0;
                starve[j] = 0;
            end
        end
        done = rstn && pv[k] && (pdue[k] == cyc);
        free = rstn && (!pv[k] || done);
        e0 = 1'b0;
        e1 = 1'b0;
        if (free && (q0 || q1)) begin
            if (q0 && (!q1 || starve[k] == SMAX)) e0 = 1'b1;
            else e1 = 1'b1;
        end
        ewe = e1 && we1;
        chk("m0_gnt", 32'(og0), 32'(e0));
        chk("m1_gnt", 32'(og1), 32'(e1));
        chk("mem_en", 32'(oen), 32'(e0 | e1));
        chk("mem_we", 32'(owe), 32'(ewe));
        chk("mem_wstrb", 32'(ows), ewe ? 32'(ws1) : 32'h0);
        if (e0 || e1) chk("mem_addr", oaddr, e0 ? a0 : a1);
        if (ewe) chk("mem_wdata", owd, wd1);
        chk("m0_rvalid", 32'(orv0), 32'(done && !pport[k]));
        chk("m1_rvalid", 32'(orv1), 32'(done && pport[k]));
        chk("m0_rdata", ord0, (done && !pport[k]) ? memf(paddr[k]) : 32'h0);
        chk("m1_rdata", ord1, (done && pport[k]) ? memf(paddr[k]) : 32'h0);
        if (done) pv[k] = 1'b0;
        if ((e0 || e1) && !ewe) begin
            pv[k]    = 1'b1;
            pport[k] = e1;
            paddr[k] = e0 ? a0 : a1;
            pdue[k]  = cyc + lat_of[k];
        end
        if (e0) starve[k] = 0;
        else if (e1 && q0 && starve[k] < SMAX) starve[k]++;
        o0  = og0;
        o1  = og1;
        rv0 = orv0;
    endtask

    task automatic tick(output bit e0, output bit e1, output logic o0, output logic o1,
                        output logic rv0);
        apply();
        @(negedge clk);
        check_cycle(e0, e1, o0, o1, rv0);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        bit e0, e1;
        logic o0, o1, rv0;
        q0 = 1'b0;
        q1 = 1'b0;
        for (int i = 0; i < n; i++) tick(e0, e1, o0, o1, rv0);
    endtask

    task automatic rand_phase(input int n);
        bit e0, e1;
        logic o0, o1, rv0;
        for (int i = 0; i < n; i++) begin
            if (!q0 && $urandom_range(0, 1) == 1) begin
                q0 = 1'b1;
                a0 = 32'($urandom_range(0, 1023)) << 2;
            end
            if (!q1 && $urandom_range(0, 2) != 0) begin
                q1  = 1'b1;
                we1 = 1'($urandom_range(0, 1));
                a1  = 32'($urandom_range(0, 1023)) << 2;
                wd1 = $urandom;
                ws1 = 4'($urandom_range(1, 15));
            end
            tick(e0, e1, o0, o1, rv0);
            if (e0) q0 = 1'b0;
            if (e1) q1 = 1'b0;
            else if (q1 && $urandom_range(0, 31) == 0) q1 = 1'b0;
        end
    endtask

    initial begin
        bit e0, e1;
        logic o0, o1, rv0;
        int n, seen, ng, nrv, first, last, t0, t1;

        rstn = 1'b0;
        q0 = 1'b0; q1 = 1'b0; we1 = 1'b0;
        a0 = '0; a1 = '0; wd1 = '0; ws1 = '0;
        k = 0;
        drain(2);
        k = 1;
        drain(1);
        rstn = 1'b1;

        // Single fetch read at latency 1.
        k = 0;
        q0 = 1'b1; a0 = 32'h10;
        tick(e0, e1, o0, o1, rv0);
        q0 = 1'b0;
        tick(e0, e1, o0, o1, rv0);
        chk("t1_rvalid", 32'(rv0), 32'h1);

        // Data write beats a pending fetch, fetch follows next cycle.
        q0 = 1'b1; a0 = 32'h20;
        q1 = 1'b1; we1 = 1'b1; a1 = 32'h100; wd1 = 32'h12345678; ws1 = 4'hF;
        tick(e0, e1, o0, o1, rv0);
        chk("t2_wr_gnt", 32'(o1), 32'h1);
        q1 = 1'b0;
        tick(e0, e1, o0, o1, rv0);
        chk("t2_rd_gnt", 32'(o0), 32'h1);
        q0 = 1'b0;
        drain(2);

        // Starvation: continuous data reads while a fetch waits.
        q0 = 1'b1; a0 = 32'h30;
        q1 = 1'b1; we1 = 1'b0; a1 = 32'h1000;
        n = 0; seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            tick(e0, e1, o0, o1, rv0);
            if (o1 && !o0) n++;
            if (o0) seen = 1;
            if (e1) a1 += 4;
            if (e0) a0 += 4;
        end
        chk("starve_run", 32'(n), 32'(SMAX));
        for (int i = 0; i < 12; i++) begin
            tick(e0, e1, o0, o1, rv0);
            if (e1) a1 += 4;
            if (e0) a0 += 4;
        end
        drain(3);

        // Eight back-to-back fetch reads at latency 1.
        q0 = 1'b1; a0 = 32'h200;
        ng = 0; nrv = 0; first = -1; last = -1;
        for (int i = 0; i < 11; i++) begin
            tick(e0, e1, o0, o1, rv0);
            if (o0) begin
                ng++;
                if (first < 0) first = i;
                last = i;
            end
            if (rv0) nrv++;
            if (e0) begin
                a0 += 4;
                if (ng == 8) q0 = 1'b0;
            end
        end
        chk("b2b_gnt", 32'(ng), 32'd8);
        chk("b2b_rvalid", 32'(nrv), 32'd8);
        chk("b2b_span", 32'(last - first), 32'd7);
        drain(2);

        // Latency 3: data read then fetch read, fetch granted alongside data rvalid.
        k = 1;
        q1 = 1'b1; we1 = 1'b0; a1 = 32'h400;
        q0 = 1'b1; a0 = 32'h500;
        t0 = -1; t1 = -1;
        for (int i = 0; i < 8; i++) begin
            tick(e0, e1, o0, o1, rv0);
            if (o1 && t1 < 0) t1 = i;
            if (o0 && t0 < 0) t0 = i;
            if (e1) q1 = 1'b0;
            if (e0) q0 = 1'b0;
        end
        chk("lat3_gap", 32'(t0 - t1), 32'd3);
        drain(2);

        // Reset pulsed while a data read is outstanding.
        q1 = 1'b1; we1 = 1'b0; a1 = 32'h600;
        tick(e0, e1, o0, o1, rv0);
        a1 = 32'h640;
        tick(e0, e1, o0, o1, rv0);
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) tick(e0, e1, o0, o1, rv0);
        rstn = 1'b1;
        tick(e0, e1, o0, o1, rv0);
        chk("rst_regrant", 32'(o1), 32'h1);
        q1 = 1'b0;
        nrv = 0;
        for (int i = 0; i < 5; i++) begin
            tick(e0, e1, o0, o1, rv0);
            if (ifb.m1_rvalid === 1'b1) nrv++;
        end
        chk("rst_rvalid_cnt", 32'(nrv), 32'd1);

        // Randomized traffic on both latencies.
        k = 0;
        rand_phase(300);
        drain(4);
        k = 1;
        rand_phase(300);
        drain(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port (m0) and the CPU load/store port (m1).
- Sits between the CPU core and the on-chip RAM inside top.
- Fixed priority to data (m1), with a starvation guard that forces a fetch grant.
- One transaction is in flight at a time; reads complete MEM_LAT cycles after grant.

Parameters:
- AW, 32, address width (byte address, passed through unchanged).
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..7.
- STARVE_MAX, 4, consecutive m1 grants with m0 pending before m0 is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- m0_req  in  1  fetch request; held with m0_addr stable until m0_gnt is seen.
- m0_addr  in  AW  fetch address.
- m0_gnt  out  1  fetch grant; high for exactly one cycle per accepted request.
- m0_rvalid  out  1  fetch read data valid; one-cycle pulse.
- m0_rdata  out  DW  fetch read data.
- m1_req  in  1  data request; held until m1_gnt is seen.
- m1_we  in  1  1 = write, 0 = read.
- m1_addr  in  AW  data address.
- m1_wdata  in  DW  write data.
- m1_wstrb  in  DW/8  byte write enables.
- m1_gnt  out  1  data grant.
- m1_rvalid  out  1  data read valid; never asserted for writes.
- m1_rdata  out  DW  data read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wstrb  out  DW/8  memory byte enables; all zero on reads.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (asynchronous, rstn=0):
  - State goes to IDLE; lat_cnt=0, starve_cnt=0, owner=0.
  - All gnt, rvalid, mem_en, mem_we outputs are 0; mem_wstrb is 0.
  - Any in-flight read is discarded; no rvalid is produced after reset release.
- State machine:
  - IDLE: arbitrate whenever any req is high.
  - WAIT: a read is outstanding; lat_cnt counts 1..MEM_LAT.
- Arbitration (combinational, in IDLE or on the final WAIT cycle):
  - m1 wins, unless m0_req=1 and starve_cnt==STARVE_MAX; then m0 wins.
  - The winner's gnt and mem_en are high in the same cycle.
  - mem_addr, mem_we, mem_wdata, mem_wstrb are muxed from the winner in that cycle.
  - m0 requests are always reads (mem_we=0).
- Writes:
  - Complete in the grant cycle.
  - State remains IDLE; the next grant is possible on the very next cycle.
- Reads:
  - On grant, register owner, set lat_cnt=1, go to WAIT.
  - When lat_cnt==MEM_LAT: the owner's rvalid=1 and the owner's rdata=mem_rdata (combinational pass-through).
  - In that same cycle a new grant may issue (back-to-back); go to WAIT if the new grant is a read, otherwise IDLE.
  - With MEM_LAT=1 this sustains one read per cycle.
- No grants are issued while lat_cnt<MEM_LAT in WAIT. Requests stay pending and the requester keeps holding them.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on every m1 grant while m0_req=1.
  - Clears on any m0 grant.
  - Holds otherwise.
- rdata for the non-owner port is don't-care; it is driven 0.
- Simultaneous events: a requester whose rvalid is high may have its next req granted in the same cycle.
- A req dropped before grant is a protocol violation. The arbiter tolerates it with no grant and no state change.

Test Plan:
- Reset, then m0_req with addr 0x10 and mem_rdata=0xDEADBEEF, MEM_LAT=1 -> m0_gnt and mem_en at cycle 0, m0_rvalid at cycle 1 with m0_rdata=0xDEADBEEF; m1 outputs stay 0.
- m0 and m1 both request; m1 write to 0x100, wdata=0x12345678, wstrb=0xF -> m1_gnt and mem_we=1 at cycle 0, m0_gnt at cycle 1.
- m1 issues continuous reads with m0_req held high, STARVE_MAX=4 -> m1 granted 4 times, 5th grant goes to m0, and starve_cnt returns to 0.
- MEM_LAT=3, m1 read then m0 read -> m1_rvalid 3 cycles after m1_gnt; m0_gnt coincides with m1_rvalid; no grant in the 2 intermediate cycles.
- rstn pulsed low during WAIT of an m1 read -> no m1_rvalid appears afterward, all outputs read 0 during reset, and the next request is served normally.
- Back-to-back m0 reads at MEM_LAT=1 for 8 cycles -> 8 consecutive m0_gnt pulses and 8 consecutive rvalid pulses, each data matching its address.
